ysyx_23060332_reg_wb_arb: RTL and testbench

- Write-back controller in front of the 2R1W register file's single write port.
- Arbitrates two write-back requesters onto that port: req0 = EXU ALU result, req1 = LSU load data.
- Registers the winning write for one cycle before it reaches the register file.
- Keeps a per-register pending-write scoreboard, so the IDU can stall on RAW hazards.

---
 rtl/ysyx_23060332_reg_wb_arb_pkg.sv | 14 +
 rtl/ysyx_23060332_reg_wb_arb_if.sv | 42 ++++
 rtl/ysyx_23060332_arb2.sv | 38 +++
 rtl/ysyx_23060332_reg_wb_arb.sv | 102 ++++++++++
 tb/tb_ysyx_23060332_reg_wb_arb.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060332_reg_wb_arb_pkg.sv
// Shared register-file widths, write-back source encoding and scoreboard counter width.
// Imported by the write-back arbiter and its interface.
package ysyx_23060332_reg_wb_arb_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegDataBus = 32;
    localparam int SbCntW     = 2;

    typedef enum logic {
        WB_SRC_EXU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/ysyx_23060332_reg_wb_arb_if.sv
// Write-back bundle: IDU issue port, two requesters, register-file write port and busy vector.
// master = the surrounding pipeline, slave = the write-back arbiter.
interface ysyx_23060332_reg_wb_arb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
);
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_ready;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_waddr;
    logic [DATA_W-1:0] req0_wdata;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_waddr;
    logic [DATA_W-1:0] req1_wdata;

    logic              reg_wen;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output iss_valid, iss_rd,
        output req0_valid, req0_waddr, req0_wdata,
        output req1_valid, req1_waddr, req1_wdata,
        input  iss_ready, req0_ready, req1_ready,
        input  reg_wen, reg_waddr, reg_wdata, busy_vec
    );

    modport slave (
        input  iss_valid, iss_rd,
        input  req0_valid, req0_waddr, req0_wdata,
        input  req1_valid, req1_waddr, req1_wdata,
        output iss_ready, req0_ready, req1_ready,
        output reg_wen, reg_waddr, reg_wdata, busy_vec
    );
endinterface

// File: rtl/ysyx_23060332_arb2.sv
// Two-way grant logic, combinational from req (and the pointer); fixed req1-over-req0 priority,
// or round-robin with a pointer flop when YSYX_23060332_WB_RR_EN is defined.
module ysyx_23060332_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef YSYX_23060332_WB_RR_EN
    logic ptr;
    logic contested;

    assign contested = req[0] & req[1];

    always_comb begin
        gnt = req;
        if (contested) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // The side that just won a contest loses the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (contested) begin
            ptr <= gnt[0];
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{clk, rst};
    assign gnt       = {req[1], req[0] & ~req[1]};
`endif

endmodule

// File: rtl/ysyx_23060332_reg_wb_arb.sv
// Write-back arbiter + registered write stage (1 cycle grant-to-reg_wen) + pending-write scoreboard.
// Never stalls the register file; losers hold valid; iss_ready drops on a saturated counter.
module ysyx_23060332_reg_wb_arb
    import ysyx_23060332_reg_wb_arb_pkg::*;
#(
    parameter int ADDR_W = RegAddrBus,
    parameter int DATA_W = RegDataBus,
    parameter int NREG   = 32,
    parameter int CNT_W  = SbCntW
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_23060332_reg_wb_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_t;

    logic [1:0] gnt;
    wb_src_e    win_src;
    wb_t        win;
    logic       xfer;

    ysyx_23060332_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bus.req1_valid, bus.req0_valid}),
        .gnt (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign xfer           = |gnt;

    always_comb begin
        win_src = gnt[1] ? WB_SRC_LSU : WB_SRC_EXU;
        if (win_src == WB_SRC_LSU) begin
            win.waddr = bus.req1_waddr;
            win.wdata = bus.req1_wdata;
        end else begin
            win.waddr = bus.req0_waddr;
            win.wdata = bus.req0_wdata;
        end
    end

    logic wen_q;
    wb_t  wb_q;

    // x0 writes are accepted from the requester but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q <= 1'b0;
            wb_q  <= '0;
        end else begin
            wen_q <= xfer && (win.waddr != '0);
            if (xfer) begin
                wb_q <= win;
            end
        end
    end

    assign bus.reg_wen   = wen_q;
    assign bus.reg_waddr = wb_q.waddr;
    assign bus.reg_wdata = wb_q.wdata;

    logic [CNT_W-1:0] cnt [NREG];
    logic             iss_fire;

    assign bus.iss_ready = (bus.iss_rd == '0) || (cnt[bus.iss_rd] != CntMax);
    assign iss_fire      = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);

    for (genvar i = 0; i < NREG; i++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = iss_fire && (bus.iss_rd == ADDR_W'(i));
        assign dec = wen_q && (wb_q.waddr == ADDR_W'(i));

        // Simultaneous issue and commit cancel; a commit never drives a counter below zero.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt[i] <= '0;
            end else if (inc && !dec) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end else if (dec && !inc && (cnt[i] != '0)) begin
                cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.busy_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            bus.busy_vec[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_reg_wb_arb.sv
// Scoreboard bench: reference model predicts grants, writes and pending counts; a monitor checks writes.
module tb_ysyx_23060332_reg_wb_arb;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int NREG    = 32;
    localparam int CNT_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ysyx_23060332_reg_wb_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) bus ();

    ysyx_23060332_reg_wb_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .CNT_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        int          addr;
        logic [31:0] data;
    } exp_wr_t;

    exp_wr_t exp_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc    = 0;

    int mcnt[NREG];
    bit pend_v  = 1'b0;
    int pend_a  = 0;
    int last_cw = 1;
    bit g0_m    = 1'b0;
    bit g1_m    = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Reference model: decides grants from the arbitration rule and tracks pending writes per register.
    always @(negedge clk) begin : model
        int          winner;
        bit          iss_ok;
        bit          inc;
        int          a;
        logic [31:0] d;
        logic [NREG-1:0] exp_busy;
        if (!rst) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            pend_v  = 1'b0;
            last_cw = 1;
            g0_m    = 1'b0;
            g1_m    = 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) exp_busy[i] = (mcnt[i] != 0);
            chk("busy_vec", bus.busy_vec, exp_busy);

            winner = -1;
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef YSYX_23060332_WB_RR_EN
                winner  = (last_cw == 0) ? 1 : 0;
                last_cw = winner;
`else
                winner = 1;
`endif
            end else if (bus.req1_valid) begin
                winner = 1;
            end else if (bus.req0_valid) begin
                winner = 0;
            end
            chk("req0_ready", bus.req0_ready, winner == 0);
            chk("req1_ready", bus.req1_ready, winner == 1);

            iss_ok = (bus.iss_rd == 0) || (mcnt[bus.iss_rd] < CNT_MAX);
            chk("iss_ready", bus.iss_ready, iss_ok);

            inc = bus.iss_valid && iss_ok && (bus.iss_rd != 0);
            if (!(inc && pend_v && (int'(bus.iss_rd) == pend_a))) begin
                if (inc) mcnt[bus.iss_rd]++;
                if (pend_v && mcnt[pend_a] > 0) mcnt[pend_a]--;
            end

            pend_v = 1'b0;
            if (winner >= 0) begin
                a = (winner == 1) ? int'(bus.req1_waddr) : int'(bus.req0_waddr);
                d = (winner == 1) ? bus.req1_wdata : bus.req0_wdata;
                if (a != 0) begin
                    pend_v = 1'b1;
                    pend_a = a;
                    exp_q.push_back('{due: cyc + 1, addr: a, data: d});
                end
            end
            g0_m = (winner == 0);
            g1_m = (winner == 1);
        end
    end

    // Write-port monitor: every cycle the register-file port must match the oldest due entry or be idle.
    always @(negedge clk) begin : monitor
        exp_wr_t e;
        if (!rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("reg_wen", bus.reg_wen, 1);
            chk("reg_waddr", bus.reg_waddr, e.addr);
            chk("reg_wdata", bus.reg_wdata, e.data);
        end else begin
            chk("reg_wen_idle", bus.reg_wen, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_req();
        step();
        if (g0_m) bus.req0_valid = 1'b0;
        if (g1_m) bus.req1_valid = 1'b0;
    endtask

    task automatic idle();
        bus.iss_valid  = 1'b0;
        bus.iss_rd     = '0;
        bus.req0_valid = 1'b0;
        bus.req0_waddr = '0;
        bus.req0_wdata = '0;
        bus.req1_valid = 1'b0;
        bus.req1_waddr = '0;
        bus.req1_wdata = '0;
    endtask

    task automatic put0(input int a, input logic [31:0] d);
        bus.req0_valid = 1'b1;
        bus.req0_waddr = ADDR_W'(a);
        bus.req0_wdata = d;
    endtask

    task automatic put1(input int a, input logic [31:0] d);
        bus.req1_valid = 1'b1;
        bus.req1_waddr = ADDR_W'(a);
        bus.req1_wdata = d;
    endtask

    initial begin
        idle();
        repeat (2) step();
        chk("rst_reg_wen", bus.reg_wen, 0);
        chk("rst_reg_waddr", bus.reg_waddr, 0);
        chk("rst_reg_wdata", bus.reg_wdata, 0);
        chk("rst_busy_vec", bus.busy_vec, 0);
        rst = 1'b1;
        step();

        // Lone EXU write.
        put0(5, 32'hDEADBEEF);
        step_req();
        chk("t1_wen", bus.reg_wen, 1);
        chk("t1_waddr", bus.reg_waddr, 5);
        chk("t1_wdata", bus.reg_wdata, 32'hDEADBEEF);
        step();
        chk("t1_wen_after", bus.reg_wen, 0);

        // Contested grant.
        put0(3, 32'h0000_0033);
        put1(4, 32'h0000_0044);
        step_req();
`ifdef YSYX_23060332_WB_RR_EN
        chk("t2_first_waddr", bus.reg_waddr, 3);
`else
        chk("t2_first_waddr", bus.reg_waddr, 4);
`endif
        step_req();
`ifdef YSYX_23060332_WB_RR_EN
        chk("t2_second_waddr", bus.reg_waddr, 4);
`else
        chk("t2_second_waddr", bus.reg_waddr, 3);
`endif
        idle();
        step();

        // Saturate register 7, then drain it.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        repeat (3) step();
        bus.iss_valid = 1'b0;
        #1;
        chk("t3_sat_ready", bus.iss_ready, 0);
        chk("t3_busy7", bus.busy_vec[7], 1);
        put0(7, 32'h7777_0001);
        step_req();
        step();
        chk("t3_ready_back", bus.iss_ready, 1);
        put0(7, 32'h7777_0002);
        step_req();
        put0(7, 32'h7777_0003);
        step_req();
        step();
        chk("t3_busy7_clear", bus.busy_vec[7], 0);

        // Issue and commit to register 9 in the same cycle.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        put0(9, 32'h9999_0001);
        step_req();
        chk("t4_busy9_set", bus.busy_vec[9], 1);
        step();
        bus.iss_valid = 1'b0;
        step();
        chk("t4_busy9_held", bus.busy_vec[9], 1);
        put0(9, 32'h9999_0002);
        step_req();
        step();
        step();

        // x0 write and x0 issue.
        put1(0, 32'h0BAD_0BAD);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        step_req();
        chk("t5_x0_wen", bus.reg_wen, 0);
        chk("t5_x0_ready", bus.iss_ready, 1);
        step();
        chk("t5_busy_zero", bus.busy_vec, 0);
        idle();

        // Asynchronous reset while a write is on the port.
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        step();
        bus.iss_rd    = 5'd8;
        step();
        bus.iss_valid = 1'b0;
        put0(7, 32'hCAFE_F00D);
        step_req();
        chk("t6_pre_wen", bus.reg_wen, 1);
        chk("t6_pre_busy", bus.busy_vec, 32'h0000_0180);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_wen", bus.reg_wen, 0);
        chk("t6_async_busy", bus.busy_vec, 0);
        idle();
        step();
        rst = 1'b1;
        step();

        // Randomized traffic with the hold-until-granted rule.
        for (int n = 0; n < 3000; n++) begin
            if (!(bus.req0_valid && !g0_m)) begin
                bus.req0_valid = ($urandom_range(0, 99) < 45);
                bus.req0_waddr = ADDR_W'($urandom_range(0, 5));
                bus.req0_wdata = $urandom;
            end
            if (!(bus.req1_valid && !g1_m)) begin
                bus.req1_valid = ($urandom_range(0, 99) < 35);
                bus.req1_waddr = ADDR_W'($urandom_range(0, 5));
                bus.req1_wdata = $urandom;
            end
            bus.iss_valid = ($urandom_range(0, 99) < 50);
            bus.iss_rd    = ADDR_W'($urandom_range(0, 5));
            step();
        end

        idle();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
